// File: rtl/guess_entry.sv
// Three-digit guess entry: collects keypad digits, supports backspace/clear/enter,
// commits the guess to oNum1-3 with a one-cycle strobe, and auto-clears stale entries.
module guess_entry #(
  parameter bit          ALLOW_DUP = 1'b0,
  parameter logic [31:0] TIMEOUT   = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] entry1,
  output logic [3:0] entry2,
  output logic [3:0] entry3,
  output logic [1:0] entry_cnt,
  output logic [3:0] oNum1,
  output logic [3:0] oNum2,
  output logic [3:0] oNum3,
  output logic       oNumRdy,
  output logic       err,
  output logic       tmo,
  output logic [3:0] guess_cnt,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {S_EMPTY, S_PART, S_FULL, S_SEND} state_t;

  state_t          state, state_n;
  logic [2:0][3:0] slot, slot_n;
  logic [2:0][3:0] onum, onum_n;
  logic [1:0]      cnt, cnt_n;
  logic [3:0]      guess, guess_n;
  logic [31:0]     idle, idle_n;
  logic            err_n, tmo_n, rdy_n;
  logic            dup;

  // key_valid is a one-cycle strobe with no backpressure: every strobe is consumed
  // on the edge that samples it, except during S_SEND where it is dropped silently.
  assign dup = ((cnt > 2'd0) && (slot[0] == key_code)) ||
               ((cnt > 2'd1) && (slot[1] == key_code));

  always_comb begin
    state_n = state;
    slot_n  = slot;
    cnt_n   = cnt;
    onum_n  = onum;
    guess_n = guess;
    idle_n  = idle + 32'd1;
    err_n   = 1'b0;
    tmo_n   = 1'b0;
    rdy_n   = 1'b0;
    if (state == S_SEND) begin
      onum_n  = slot;
      rdy_n   = 1'b1;
      guess_n = (guess == 4'd15) ? guess : guess + 4'd1;
      slot_n  = '0;
      cnt_n   = 2'd0;
      idle_n  = 32'd0;
      state_n = S_EMPTY;
    end else if (key_valid) begin
      idle_n = 32'd0;
      case (key_code)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
          if (state == S_FULL || (!ALLOW_DUP && dup)) begin
            err_n = 1'b1;
          end else begin
            slot_n[cnt] = key_code;
            cnt_n       = cnt + 2'd1;
            state_n     = (cnt == 2'd2) ? S_FULL : S_PART;
          end
        end
        4'hA: begin
          if (cnt != 2'd0) begin
            slot_n[cnt - 2'd1] = 4'd0;
            cnt_n              = cnt - 2'd1;
            state_n            = (cnt == 2'd1) ? S_EMPTY : S_PART;
          end
        end
        4'hB: begin
          slot_n  = '0;
          cnt_n   = 2'd0;
          state_n = S_EMPTY;
        end
        4'hE: begin
          if (state == S_FULL) state_n = S_SEND;
          else                 err_n   = 1'b1;
        end
        default: ;
      endcase
    end else if (state == S_EMPTY) begin
      idle_n = 32'd0;
    end else if (idle == TIMEOUT - 32'd1) begin
      slot_n  = '0;
      cnt_n   = 2'd0;
      idle_n  = 32'd0;
      tmo_n   = 1'b1;
      state_n = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_EMPTY;
      slot    <= '0;
      onum    <= '0;
      cnt     <= 2'd0;
      guess   <= 4'd0;
      idle    <= 32'd0;
      err     <= 1'b0;
      tmo     <= 1'b0;
      oNumRdy <= 1'b0;
    end else begin
      state   <= state_n;
      slot    <= slot_n;
      onum    <= onum_n;
      cnt     <= cnt_n;
      guess   <= guess_n;
      idle    <= idle_n;
      err     <= err_n;
      tmo     <= tmo_n;
      oNumRdy <= rdy_n;
    end
  end

  assign entry1    = slot[0];
  assign entry2    = slot[1];
  assign entry3    = slot[2];
  assign entry_cnt = cnt;
  assign oNum1     = onum[0];
  assign oNum2     = onum[1];
  assign oNum3     = onum[2];
  assign guess_cnt = guess;
  assign fsm_state = state;

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: two instances (duplicates rejected / allowed) share the same
// key stream and are compared every cycle against a digit-list reference model.
module tb_guess_entry;

  localparam int TMO = 10;

  logic       clk, reset, key_valid;
  logic [3:0] key_code;

  logic [3:0] a_e1, a_e2, a_e3, a_o1, a_o2, a_o3, a_gc;
  logic [1:0] a_cnt, a_st;
  logic       a_rdy, a_err, a_tmo;
  logic [3:0] b_e1, b_e2, b_e3, b_o1, b_o2, b_o3, b_gc;
  logic [1:0] b_cnt, b_st;
  logic       b_rdy, b_err, b_tmo;

  guess_entry #(.ALLOW_DUP(1'b0), .TIMEOUT(32'd10)) dut_a (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .entry1(a_e1), .entry2(a_e2), .entry3(a_e3), .entry_cnt(a_cnt),
    .oNum1(a_o1), .oNum2(a_o2), .oNum3(a_o3), .oNumRdy(a_rdy),
    .err(a_err), .tmo(a_tmo), .guess_cnt(a_gc), .fsm_state(a_st)
  );

  guess_entry #(.ALLOW_DUP(1'b1), .TIMEOUT(32'd10)) dut_b (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .entry1(b_e1), .entry2(b_e2), .entry3(b_e3), .entry_cnt(b_cnt),
    .oNum1(b_o1), .oNum2(b_o2), .oNum3(b_o3), .oNumRdy(b_rdy),
    .err(b_err), .tmo(b_tmo), .guess_cnt(b_gc), .fsm_state(b_st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: index 0 rejects duplicates, index 1 allows them
  logic [3:0]  m_dig  [2][3];
  logic [3:0]  m_onum [2][3];
  int          m_n    [2];
  int          m_guess[2];
  int unsigned m_idle [2];
  bit          m_pend [2];
  bit          m_err  [2];
  bit          m_tmo  [2];
  bit          m_rdy  [2];

  task automatic clear_entry(input int k);
    for (int i = 0; i < 3; i++) m_dig[k][i] = 4'd0;
    m_n[k] = 0;
  endtask

  task automatic model_step(input int k, input bit rst, input bit kv, input logic [3:0] code);
    bit dupl;
    m_err[k] = 0; m_tmo[k] = 0; m_rdy[k] = 0;
    if (rst) begin
      clear_entry(k);
      for (int i = 0; i < 3; i++) m_onum[k][i] = 4'd0;
      m_pend[k] = 0; m_idle[k] = 0; m_guess[k] = 0;
    end else if (m_pend[k]) begin
      for (int i = 0; i < 3; i++) m_onum[k][i] = m_dig[k][i];
      m_rdy[k] = 1;
      if (m_guess[k] < 15) m_guess[k]++;
      clear_entry(k);
      m_pend[k] = 0; m_idle[k] = 0;
    end else if (kv) begin
      m_idle[k] = 0;
      if (code <= 4'd9) begin
        dupl = 0;
        for (int i = 0; i < m_n[k]; i++) if (m_dig[k][i] == code) dupl = 1;
        if (m_n[k] == 3 || (k == 0 && dupl)) m_err[k] = 1;
        else begin
          m_dig[k][m_n[k]] = code;
          m_n[k]++;
        end
      end else if (code == 4'hA) begin
        if (m_n[k] > 0) begin
          m_n[k]--;
          m_dig[k][m_n[k]] = 4'd0;
        end
      end else if (code == 4'hB) begin
        clear_entry(k);
      end else if (code == 4'hE) begin
        if (m_n[k] == 3) m_pend[k] = 1;
        else             m_err[k]  = 1;
      end
    end else if (m_n[k] == 0) begin
      m_idle[k] = 0;
    end else if (m_idle[k] == TMO - 1) begin
      clear_entry(k);
      m_tmo[k] = 1; m_idle[k] = 0;
    end else begin
      m_idle[k]++;
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input logic [3:0] e1, input logic [3:0] e2,
                           input logic [3:0] e3, input logic [1:0] ec,
                           input logic [3:0] o1, input logic [3:0] o2, input logic [3:0] o3,
                           input logic rdy, input logic er, input logic tm, input logic [3:0] gc);
    string p;
    p = (k == 0) ? "nodup" : "dup";
    chk({p, "_entry1"},    32'(e1),  32'(m_dig[k][0]));
    chk({p, "_entry2"},    32'(e2),  32'(m_dig[k][1]));
    chk({p, "_entry3"},    32'(e3),  32'(m_dig[k][2]));
    chk({p, "_entry_cnt"}, 32'(ec),  32'(m_n[k]));
    chk({p, "_oNum1"},     32'(o1),  32'(m_onum[k][0]));
    chk({p, "_oNum2"},     32'(o2),  32'(m_onum[k][1]));
    chk({p, "_oNum3"},     32'(o3),  32'(m_onum[k][2]));
    chk({p, "_oNumRdy"},   32'(rdy), 32'(m_rdy[k]));
    chk({p, "_err"},       32'(er),  32'(m_err[k]));
    chk({p, "_tmo"},       32'(tm),  32'(m_tmo[k]));
    chk({p, "_guess_cnt"}, 32'(gc),  32'(m_guess[k]));
  endtask

  // driver: apply inputs, step the model on the edge, check 1 time unit later
  task automatic cycle(input bit kv, input logic [3:0] code, input bit rst = 1'b0);
    reset = rst; key_valid = kv; key_code = code;
    @(posedge clk);
    model_step(0, rst, kv, code);
    model_step(1, rst, kv, code);
    #1;
    check_dut(0, a_e1, a_e2, a_e3, a_cnt, a_o1, a_o2, a_o3, a_rdy, a_err, a_tmo, a_gc);
    check_dut(1, b_e1, b_e2, b_e3, b_cnt, b_o1, b_o2, b_o3, b_rdy, b_err, b_tmo, b_gc);
  endtask

  task automatic key(input logic [3:0] code);
    cycle(1'b1, code);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0);
  endtask

  initial begin
    int r;
    logic [3:0] c;
    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b1, 4'h5, 1'b1);
    chk("reset_entry_cnt", 32'(a_cnt), 32'd0);
    chk("reset_guess_cnt", 32'(a_gc), 32'd0);

    // basic commit, oNumRdy two cycles after enter
    key(4'h1); chk("s030_cnt1", 32'(a_cnt), 32'd1);
    key(4'h2); chk("s030_cnt2", 32'(a_cnt), 32'd2);
    key(4'h3); chk("s030_cnt3", 32'(a_cnt), 32'd3);
    key(4'hE); chk("s030_rdy_early", 32'(a_rdy), 32'd0);
    idle_cycles(1);
    chk("s030_rdy", 32'(a_rdy), 32'd1);
    chk("s030_onum", 32'({a_o1, a_o2, a_o3}), 32'h123);
    chk("s030_guess", 32'(a_gc), 32'd1);
    chk("s030_cnt0", 32'(a_cnt), 32'd0);
    idle_cycles(1);
    chk("s030_rdy_once", 32'(a_rdy), 32'd0);

    // duplicate digit handling on both instances
    key(4'h4); key(4'h4);
    chk("s031_nodup_err", 32'(a_err), 32'd1);
    chk("s031_nodup_cnt", 32'(a_cnt), 32'd1);
    chk("s031_dup_cnt", 32'(b_cnt), 32'd2);
    chk("s031_dup_entry2", 32'(b_e2), 32'd4);
    key(4'hB);
    chk("s019_clear_cnt", 32'(b_cnt), 32'd0);

    // backspace, early enter, then completion
    key(4'h5); key(4'h6); key(4'hA);
    chk("s032_bs", 32'({a_e1, a_e2, a_cnt}), 32'({4'h5, 4'h0, 2'd1}));
    key(4'h7); key(4'hE);
    chk("s032_early_err", 32'(a_err), 32'd1);
    idle_cycles(1);
    chk("s032_no_rdy", 32'(a_rdy), 32'd0);
    key(4'h8); key(4'hE); idle_cycles(1);
    chk("s032_onum", 32'({a_o1, a_o2, a_o3}), 32'h578);

    // timeout at the 10th idle edge
    key(4'h9);
    idle_cycles(TMO - 1);
    chk("s033_tmo_early", 32'(a_tmo), 32'd0);
    idle_cycles(1);
    chk("s033_tmo", 32'(a_tmo), 32'd1);
    chk("s033_cnt", 32'(a_cnt), 32'd0);
    chk("s033_err", 32'(a_err), 32'd0);
    chk("s033_onum", 32'({a_o1, a_o2, a_o3}), 32'h578);
    idle_cycles(1);
    chk("s033_tmo_once", 32'(a_tmo), 32'd0);

    // guess counter saturation, then reset during commit
    cycle(1'b0, 4'h0, 1'b1);
    for (int g = 0; g < 16; g++) begin
      key(4'h1); key(4'h2); key(4'h3); key(4'hE); key(4'hE);
    end
    chk("s034_sat", 32'(a_gc), 32'd15);
    key(4'h3); key(4'h2); key(4'h1); key(4'hE);
    cycle(1'b0, 4'h0, 1'b1);
    chk("s034_rst_rdy", 32'(a_rdy), 32'd0);
    chk("s034_rst_all", 32'({a_o1, a_o2, a_o3, a_gc, a_e1, a_e2, a_e3, a_cnt}), 32'd0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) cycle(1'b0, 4'h0, 1'b1);
      else if (r < 4) idle_cycles(TMO + 1);
      else if (r < 45) idle_cycles(1);
      else begin
        r = $urandom_range(0, 99);
        if (r < 60)      c = 4'($urandom_range(0, 9));
        else if (r < 75) c = 4'hE;
        else             c = 4'($urandom_range(0, 15));
        key(c);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
